data_streamer: RTL and testbench

//  Read-side counterpart of the data loader. After the loader has filled the x/y sample

---
 rtl/data_streamer.sv | 120 ++++++++++++
 tb/tb_data_streamer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_streamer.sv
// Streams (x,y) pairs from addresses 0..len-1 of the sample memories to the regression datapath.
// Latency: first out_valid 3 cycles after start, one pair per 3 cycles; backpressure holds the pair in SEND until out_ready.
module data_streamer #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_points,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] x_mem_data,
    input  logic [DATA_W-1:0] y_mem_data,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] n_clamped;

    always_comb begin
        n_clamped = (n_points > DEPTH_A) ? DEPTH_A : n_points;
    end

    // The address register doubles as the pair counter.
    assign mem_addr = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len       <= '0;
            mem_read  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len  <= n_clamped;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (n_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_REQ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    mem_read <= 1'b0;
                    state    <= S_CAP;
                end
                S_CAP: begin
                    // Memory data is valid now, one cycle after the read strobe.
                    x_out     <= x_mem_data;
                    y_out     <= y_mem_data;
                    out_valid <= 1'b1;
                    last      <= (cnt == len - ONE_A);
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt      <= cnt + ONE_A;
                            mem_read <= 1'b1;
                            state    <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_read  <= 1'b0;
                    out_valid <= 1'b0;
                    last      <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_streamer.sv
// Bench for data_streamer: memory model x=i+1, y=2i+3 and a queue of expected pairs.
module tb_data_streamer;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 150;

    typedef struct {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              last;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] n_points;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [DATA_W-1:0] x_mem_data;
    logic [DATA_W-1:0] y_mem_data;
    logic [DATA_W-1:0] x_out;
    logic [DATA_W-1:0] y_out;
    logic              out_valid;
    logic              out_ready;
    logic              last;
    logic              busy;
    logic              done;

    int    errors = 0;
    int    checks = 0;
    pair_t exp_q[$];

    data_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .mem_addr(mem_addr), .mem_read(mem_read),
        .x_mem_data(x_mem_data), .y_mem_data(y_mem_data),
        .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready),
        .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample memories.
    always @(posedge clk) begin
        if (mem_read) begin
            x_mem_data <= DATA_W'(mem_addr) + 20'd1;
            y_mem_data <= DATA_W'(mem_addr) * 20'd2 + 20'd3;
        end
    end

    // Drives a one-cycle start (cleared by the caller's loop) and queues the expected pairs.
    task automatic pulse_start(input int n);
        int len;
        @(negedge clk);
        start    = 1'b1;
        n_points = ADDR_W'(n);
        len      = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < len; i++)
            exp_q.push_back('{DATA_W'(i + 1), DATA_W'(2 * i + 3), (i == len - 1)});
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; n_points = 8'd4; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_addr, mem_read, x_out, y_out, out_valid, last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d rd=%0b x=%0d y=%0d v=%0b last=%0b busy=%0b done=%0b, required all 0",
                     mem_addr, mem_read, x_out, y_out, out_valid, last, busy, done);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: got busy=%0b mem_read=%0b, required 0 0", busy, mem_read);
        end
    endtask

    task automatic test_basic;
        int t = 0, rd = 0, dones = 0, first_v = 0;
        out_ready = 1'b1;
        pulse_start(4);
        while (t < 100 && dones == 0) begin
            @(negedge clk); start = 1'b0; t++;
            if (t == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b required 1", busy); end
            end
            if (mem_read) begin
                checks++;
                if (mem_addr !== ADDR_W'(rd)) begin errors++; $display("FAIL basic_addr: got %0d required %0d", mem_addr, rd); end
                rd++;
            end
            if (out_valid && first_v == 0) begin
                first_v = t; checks++;
                if (t != 3) begin errors++; $display("FAIL basic_first_valid: got cycle %0d required 3", t); end
            end
            if (out_valid && out_ready) begin
                pair_t p;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra_pair: got x=%0d y=%0d required none", x_out, y_out); end
                else begin
                    p = exp_q.pop_front();
                    if ({x_out, y_out, last} !== {p.x, p.y, p.last}) begin
                        errors++;
                        $display("FAIL basic_pair: got (%0d,%0d,last=%0b) required (%0d,%0d,last=%0b)", x_out, y_out, last, p.x, p.y, p.last);
                    end
                end
            end
            if (done) begin
                dones++; checks++;
                if (t != 13) begin errors++; $display("FAIL basic_done_time: got cycle %0d required 13", t); end
            end
        end
        checks++;
        if (dones != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL basic_complete: got done=%0d left=%0d required 1 0", dones, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got done=%0b busy=%0b required 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure;
        int t = 0, rd = 0, acc = 0, hold = 0, dones = 0;
        out_ready = 1'b1;
        pulse_start(3);
        while (t < 100 && dones == 0) begin
            @(negedge clk); start = 1'b0; t++;
            out_ready = !(out_valid && acc == 1 && hold < 5);
            if (mem_read) begin
                checks++;
                if (mem_addr !== ADDR_W'(rd)) begin errors++; $display("FAIL bp_addr: got %0d required %0d", mem_addr, rd); end
                rd++;
            end
            if (out_valid && !out_ready) begin
                hold++; checks++;
                if (x_out !== exp_q[0].x || y_out !== exp_q[0].y || last !== exp_q[0].last) begin
                    errors++; $display("FAIL bp_hold_stable: got (%0d,%0d) required (%0d,%0d)", x_out, y_out, exp_q[0].x, exp_q[0].y);
                end
            end else if (out_valid) begin
                pair_t p;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_pair: got x=%0d required none", x_out); end
                else begin
                    p = exp_q.pop_front(); acc++;
                    if ({x_out, y_out, last} !== {p.x, p.y, p.last}) begin
                        errors++; $display("FAIL bp_pair: got (%0d,%0d,%0b) required (%0d,%0d,%0b)", x_out, y_out, last, p.x, p.y, p.last);
                    end
                end
            end
            if (done) begin
                dones++; checks++;
                if (t != 15) begin errors++; $display("FAIL bp_done_time: got cycle %0d required 15", t); end
            end
        end
        out_ready = 1'b1;
        checks++;
        if (rd != 3 || acc != 3 || hold != 5 || dones != 1) begin
            errors++; $display("FAIL bp_totals: got reads=%0d pairs=%0d hold=%0d done=%0d required 3 3 5 1", rd, acc, hold, dones);
        end
    endtask

    task automatic test_zero;
        int rd = 0, vld = 0, dones = 0, done_t = 0;
        pulse_start(0);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk); start = 1'b0;
            if (mem_read) rd++;
            if (out_valid) vld++;
            if (done) begin dones++; if (done_t == 0) done_t = t; end
        end
        checks++;
        if (rd != 0 || vld != 0) begin errors++; $display("FAIL zero_no_read: got reads=%0d valids=%0d required 0 0", rd, vld); end
        checks++;
        if (dones != 1 || done_t < 1 || done_t > 2) begin
            errors++; $display("FAIL zero_done: got pulses=%0d at cycle %0d required 1 pulse by cycle 2", dones, done_t);
        end
    endtask

    task automatic test_clamp;
        int t = 0, acc = 0, rd = 0, last_addr = -1, dones = 0;
        pulse_start(200);
        while (t < 3000 && dones == 0) begin
            @(negedge clk); start = 1'b0; t++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (mem_read) begin
                checks++;
                if (mem_addr !== ADDR_W'(rd)) begin errors++; $display("FAIL clamp_addr: got %0d required %0d", mem_addr, rd); end
                last_addr = int'(mem_addr); rd++;
            end
            if (out_valid && out_ready) begin
                pair_t p;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL clamp_extra_pair: got x=%0d required none", x_out); end
                else begin
                    p = exp_q.pop_front(); acc++;
                    if ({x_out, y_out, last} !== {p.x, p.y, p.last}) begin
                        errors++; $display("FAIL clamp_pair: got (%0d,%0d,%0b) required (%0d,%0d,%0b)", x_out, y_out, last, p.x, p.y, p.last);
                    end
                end
            end
            if (done) dones++;
        end
        out_ready = 1'b1;
        checks++;
        if (acc != 150 || rd != 150 || last_addr != 149 || dones != 1) begin
            errors++; $display("FAIL clamp_totals: got pairs=%0d reads=%0d last_addr=%0d done=%0d required 150 150 149 1", acc, rd, last_addr, dones);
        end
    endtask

    task automatic test_mid_reset;
        int t = 0, acc = 0, dones = 0, rd = 0;
        out_ready = 1'b1;
        pulse_start(10);
        while (t < 100 && rst == 1'b0) begin
            @(negedge clk); start = 1'b0; t++;
            if (out_valid && acc == 4) rst = 1'b1;
            else if (out_valid) begin void'(exp_q.pop_front()); acc++; end
        end
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_read, x_out, y_out, out_valid, last, busy, done} !== '0) begin
            errors++; $display("FAIL midrst_outputs: got addr=%0d rd=%0b x=%0d y=%0d v=%0b last=%0b busy=%0b done=%0b, required all 0",
                               mem_addr, mem_read, x_out, y_out, out_valid, last, busy, done);
        end
        rst = 1'b0;
        exp_q.delete();
        repeat (4) begin @(negedge clk); if (done || busy) dones++; end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles required 0", dones); end
        t = 0;
        pulse_start(2);
        while (t < 100 && dones == 0) begin
            @(negedge clk); start = 1'b0; t++;
            if (mem_read) begin
                checks++;
                if (mem_addr !== ADDR_W'(rd)) begin errors++; $display("FAIL midrst_addr: got %0d required %0d", mem_addr, rd); end
                rd++;
            end
            if (out_valid) begin
                pair_t p;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL midrst_extra_pair: got x=%0d required none", x_out); end
                else begin
                    p = exp_q.pop_front();
                    if ({x_out, y_out, last} !== {p.x, p.y, p.last}) begin
                        errors++; $display("FAIL midrst_pair: got (%0d,%0d,%0b) required (%0d,%0d,%0b)", x_out, y_out, last, p.x, p.y, p.last);
                    end
                end
            end
            if (done) begin
                dones++; checks++;
                if (t != 7 || rd != 2) begin errors++; $display("FAIL midrst_done: got cycle %0d reads %0d required 7 2", t, rd); end
            end
        end
        checks++;
        if (dones != 1 || exp_q.size() != 0) begin errors++; $display("FAIL midrst_complete: got done=%0d left=%0d required 1 0", dones, exp_q.size()); end
    endtask

    task automatic test_start_while_busy;
        int t = 0, dones = 0, acc = 0;
        out_ready = 1'b1;
        pulse_start(4);
        while (t < 100 && dones == 0) begin
            @(negedge clk); start = 1'b0; t++;
            if (t == 4) begin start = 1'b1; n_points = 8'd1; end
            if (out_valid) begin
                pair_t p;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL busy_start_extra_pair: got x=%0d required none", x_out); end
                else begin
                    p = exp_q.pop_front(); acc++;
                    if ({x_out, y_out, last} !== {p.x, p.y, p.last}) begin
                        errors++; $display("FAIL busy_start_pair: got (%0d,%0d,%0b) required (%0d,%0d,%0b)", x_out, y_out, last, p.x, p.y, p.last);
                    end
                end
            end
            if (done) begin
                dones++; checks++;
                if (t != 13 || acc != 4) begin errors++; $display("FAIL busy_start_done: got cycle %0d pairs %0d required 13 4", t, acc); end
            end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL busy_start_timeout: got done=%0d required 1", dones); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart: got busy=%0b required 0", busy); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_points = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_clamp();
        test_mid_reset();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
